// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite colour-fetch path.
//
// Contents:
//   COLOR_W       RGB width (3:3:3)
//   SPRITE_PIXELS pixels per sprite (20x20)
//   KEY_COLOR     transparent colour key
//   MEM_ADDR_W    sprite-memory word-address width
//   element_e     sprite element codes
//   pix_flags_t   per-pixel flags carried alongside a memory read
package sprite_pkg;

  localparam int unsigned COLOR_W       = 9;
  localparam int unsigned SPRITE_PIXELS = 400;
  localparam logic [8:0]  KEY_COLOR     = 9'h1FF;
  localparam int unsigned MEM_ADDR_W    = 15;

  // Sprite element codes as used by the sprite-select stage.
  typedef enum logic [4:0] {
    BLANK   = 5'd0,
    PLAYER  = 5'd1,
    ENEMY   = 5'd2,
    BULLET  = 5'd3,
    BOMB    = 5'd4,
    BARRIER = 5'd5
  } element_e;

  // Flags that travel with a pixel while its memory read is in flight.
  typedef struct packed {
    logic active;  // display enable at the time the pixel was accepted
    logic hit;     // a sprite-memory read was issued for this pixel
  } pix_flags_t;

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth delay line with synchronous active-low clear.
//
// Parameters:
//   Width  bits per stage
//   Depth  number of register stages (>= 1)
// Ports:
//   clk    clock
//   reset  synchronous, active-low clear of every stage
//   din    data in
//   dout   data in, delayed by Depth cycles
module pipe_delay #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout
);

  logic [Width-1:0] stage_q [Depth];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(Depth); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < int'(Depth); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign dout = stage_q[Depth-1];

endmodule

// File: rtl/sprite_color_fetch.sv
// Sprite colour fetch: turns a sprite hit (element, pixel offset) into a
// sprite-memory read and selects the final VGA pixel colour from sprite data,
// the background register, or black when the display is blanked.
//
// Pipeline: stage 0 registers the read request; the active/hit flags are then
// delayed MEM_LATENCY cycles to line up with mem_data, and the output colour is
// selected combinationally from the aligned flags. Input-to-rgb latency is
// MEM_LATENCY+1 cycles, one pixel per cycle, no stalls.
//
// Configuration macro: SPRITE_TRANSPARENCY_EN -- when defined, sprite data equal
// to KEY_COLOR is replaced by the background colour and reported as no hit.
//
// Ports:
//   clk       clock
//   reset     synchronous, active-low reset
//   active    VGA display enable
//   ready     sprite-hit strobe from sprite select
//   element   sprite index
//   address   pixel offset inside the sprite
//   mem_rd    sprite-memory read strobe (registered)
//   mem_addr  sprite-memory word address (registered, 0 when no read)
//   mem_data  sprite-memory read data, MEM_LATENCY cycles after mem_rd
//   bg_wr     background-colour write strobe
//   bg_data   background colour
//   rgb       pixel colour to the DAC
//   rgb_hit   rgb came from sprite memory
module sprite_color_fetch #(
  parameter int unsigned ELEMENT       = 5,
  parameter int unsigned SPRITE_PIXELS = sprite_pkg::SPRITE_PIXELS,
  parameter int unsigned MEM_LATENCY   = 1,
  parameter int unsigned COLOR_W       = sprite_pkg::COLOR_W,
  parameter logic [COLOR_W-1:0] KEY_COLOR = sprite_pkg::KEY_COLOR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               active,
  input  logic               ready,
  input  logic [ELEMENT-1:0] element,
  input  logic [9:0]         address,
  output logic               mem_rd,
  output logic [14:0]        mem_addr,
  input  logic [COLOR_W-1:0] mem_data,
  input  logic               bg_wr,
  input  logic [COLOR_W-1:0] bg_data,
  output logic [COLOR_W-1:0] rgb,
  output logic               rgb_hit
);

  import sprite_pkg::*;

  if (MEM_LATENCY < 1 || MEM_LATENCY > 3) begin : g_bad_latency
    $error("sprite_color_fetch: MEM_LATENCY must be 1..3");
  end

`ifdef SPRITE_TRANSPARENCY_EN
  localparam bit TranspEn = 1'b1;
`else
  localparam bit TranspEn = 1'b0;
`endif

  // One extra bit so SPRITE_PIXELS up to 1024 compares correctly.
  localparam logic [10:0] PixLimit = 11'(SPRITE_PIXELS);

  // Request stage
  logic                  in_range;
  logic                  hit_d;
  logic [MEM_ADDR_W-1:0] addr_calc;
  logic                  mem_rd_q;
  logic [MEM_ADDR_W-1:0] mem_addr_q;
  logic                  active_q;

  // Aligned flags and background
  pix_flags_t            flags_s0;
  pix_flags_t            flags_dly;
  logic [COLOR_W-1:0]    bg_q;
  logic                  is_key;

  always_comb begin
    in_range  = ({1'b0, address} < PixLimit);
    hit_d     = ready & active & in_range;
    // Full 15-bit product; the widest legal case (31*400+1023) still fits.
    addr_calc = MEM_ADDR_W'(element) * MEM_ADDR_W'(SPRITE_PIXELS) + MEM_ADDR_W'(address);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      active_q   <= 1'b0;
      bg_q       <= '0;
    end else begin
      mem_rd_q   <= hit_d;
      mem_addr_q <= hit_d ? addr_calc : '0;
      active_q   <= active;
      if (bg_wr) begin
        bg_q <= bg_data;
      end
    end
  end

  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;

  always_comb begin
    flags_s0        = '0;
    flags_s0.active = active_q;
    flags_s0.hit    = mem_rd_q;
  end

  // Flags spend MEM_LATENCY cycles in flight, matching the memory read.
  pipe_delay #(
    .Width ($bits(pix_flags_t)),
    .Depth (MEM_LATENCY)
  ) u_flag_delay (
    .clk   (clk),
    .reset (reset),
    .din   (flags_s0),
    .dout  (flags_dly)
  );

  // Output select. The background register is read before any bg_wr on this
  // edge takes effect, so a coincident write only affects later pixels.
  always_comb begin
    rgb     = '0;
    rgb_hit = 1'b0;
    is_key  = TranspEn && (mem_data == KEY_COLOR);
    if (flags_dly.active) begin
      if (flags_dly.hit && !is_key) begin
        rgb     = mem_data;
        rgb_hit = 1'b1;
      end else begin
        rgb     = bg_q;
      end
    end
  end

endmodule

// File: tb/tb_sprite_color_fetch.sv
// Self-checking bench for sprite_color_fetch: one instance with MEM_LATENCY=1
// (table-driven vectors plus hand-written sequences) and one with
// MEM_LATENCY=3 (streaming and reset-recovery checks). Each instance has its
// own behavioural sprite memory returning mem_fn(address).
module tb_sprite_color_fetch;

  logic       clk = 1'b0;
  logic       reset;
  logic       active;
  logic       ready;
  logic [4:0] element;
  logic [9:0] address;
  logic       bg_wr;
  logic [8:0] bg_data;

  logic        mem_rd1, mem_rd3;
  logic [14:0] mem_addr1, mem_addr3;
  logic [8:0]  mem_data1, mem_data3;
  logic [8:0]  rgb1, rgb3;
  logic        rgb_hit1, rgb_hit3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sprite_color_fetch #(.MEM_LATENCY(1)) dut1 (
    .clk      (clk),
    .reset    (reset),
    .active   (active),
    .ready    (ready),
    .element  (element),
    .address  (address),
    .mem_rd   (mem_rd1),
    .mem_addr (mem_addr1),
    .mem_data (mem_data1),
    .bg_wr    (bg_wr),
    .bg_data  (bg_data),
    .rgb      (rgb1),
    .rgb_hit  (rgb_hit1)
  );

  sprite_color_fetch #(.MEM_LATENCY(3)) dut3 (
    .clk      (clk),
    .reset    (reset),
    .active   (active),
    .ready    (ready),
    .element  (element),
    .address  (address),
    .mem_rd   (mem_rd3),
    .mem_addr (mem_addr3),
    .mem_data (mem_data3),
    .bg_wr    (bg_wr),
    .bg_data  (bg_data),
    .rgb      (rgb3),
    .rgb_hit  (rgb_hit3)
  );

  // Sprite memory contents: low address bits, with two fixed words.
  function automatic logic [8:0] mem_fn(input logic [14:0] a);
    if (a == 15'd2017) return 9'h0A5;
    if (a == 15'd2020) return 9'h1FF;
    return a[8:0];
  endfunction

  // Memory models; 9'h0AA marks "no read issued" so stray use shows up.
  logic [8:0] m1_q;
  logic [8:0] m3_q [3];
  always @(posedge clk) begin
    m1_q    <= mem_rd1 ? mem_fn(mem_addr1) : 9'h0AA;
    m3_q[0] <= mem_rd3 ? mem_fn(mem_addr3) : 9'h0AA;
    m3_q[1] <= m3_q[0];
    m3_q[2] <= m3_q[1];
  end
  assign mem_data1 = m1_q;
  assign mem_data3 = m3_q[2];

`ifdef SPRITE_TRANSPARENCY_EN
  localparam logic [8:0] KeyRgb = 9'h038;
  localparam logic       KeyHit = 1'b0;
`else
  localparam logic [8:0] KeyRgb = 9'h1FF;
  localparam logic       KeyHit = 1'b1;
`endif

  typedef struct {
    logic        act;
    logic        rdy;
    logic [4:0]  elem;
    logic [9:0]  addr;
    logic        e_rd;
    logic [14:0] e_addr;
    logic [8:0]  e_rgb;
    logic        e_hit;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a, input logic r, input logic [4:0] e, input logic [9:0] ad);
    active  = a;
    ready   = r;
    element = e;
    address = ad;
  endtask

  logic [8:0] exp3 [64];

  initial begin
    // Background is 9'h038 throughout the table.
    vecs[0]  = '{1'b1, 1'b1, 5'd5,  10'd17,   1'b1, 15'd2017,  9'h0A5, 1'b1};
    vecs[1]  = '{1'b1, 1'b1, 5'd0,  10'd3,    1'b1, 15'd3,     9'h003, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 5'd1,  10'd0,    1'b1, 15'd400,   9'h190, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 5'd31, 10'd398,  1'b1, 15'd12798, 9'h1FE, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 5'd2,  10'd399,  1'b1, 15'd1199,  9'h0AF, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 5'd3,  10'd400,  1'b0, 15'd0,     9'h038, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 5'd0,  10'd1023, 1'b0, 15'd0,     9'h038, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 5'd5,  10'd17,   1'b0, 15'd0,     9'h000, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 5'd5,  10'd17,   1'b0, 15'd0,     9'h038, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 5'd5,  10'd20,   1'b1, 15'd2020,  KeyRgb, KeyHit};
    vecs[10] = '{1'b1, 1'b1, 5'd10, 10'd0,    1'b1, 15'd4000,  9'h1A0, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 5'd0,  10'd399,  1'b1, 15'd399,   9'h18F, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 5'd0,  10'd0,    1'b0, 15'd0,     9'h000, 1'b0};

    // Reset state
    reset   = 1'b0;
    bg_wr   = 1'b0;
    bg_data = 9'h000;
    drive(1'b0, 1'b0, 5'd0, 10'd0);
    repeat (3) tick();
    chk("reset mem_rd", 32'(mem_rd1), 32'd0);
    chk("reset mem_addr", 32'(mem_addr1), 32'd0);
    chk("reset rgb", 32'(rgb1), 32'd0);
    chk("reset rgb_hit", 32'(rgb_hit1), 32'd0);
    chk("reset rgb L3", 32'(rgb3), 32'd0);

    // First pixel after release: latency 2 for L=1, 4 for L=3
    reset = 1'b1;
    drive(1'b1, 1'b1, 5'd5, 10'd17);
    for (int j = 0; j < 4; j++) begin
      tick();
      if (j == 0) begin
        chk("first mem_rd", 32'(mem_rd1), 32'd1);
        chk("first mem_addr", 32'(mem_addr1), 32'd2017);
        drive(1'b0, 1'b0, 5'd0, 10'd0);
      end
      chk($sformatf("first rgb L1 c%0d", j), 32'(rgb1), (j == 1) ? 32'h0A5 : 32'h0);
      chk($sformatf("first hit L1 c%0d", j), 32'(rgb_hit1), (j == 1) ? 32'd1 : 32'd0);
      chk($sformatf("first rgb L3 c%0d", j), 32'(rgb3), (j == 3) ? 32'h0A5 : 32'h0);
    end

    // Load background 9'h038
    bg_wr   = 1'b1;
    bg_data = 9'h038;
    tick();
    bg_wr   = 1'b0;

    // Table: back-to-back vectors, request one cycle later, colour two later
    for (int i = 0; i <= NVEC; i++) begin
      if (i < NVEC) drive(vecs[i].act, vecs[i].rdy, vecs[i].elem, vecs[i].addr);
      else          drive(1'b0, 1'b0, 5'd0, 10'd0);
      tick();
      if (i < NVEC) begin
        chk($sformatf("vec%0d mem_rd", i), 32'(mem_rd1), 32'(vecs[i].e_rd));
        chk($sformatf("vec%0d mem_addr", i), 32'(mem_addr1), 32'(vecs[i].e_addr));
      end
      if (i >= 1) begin
        chk($sformatf("vec%0d rgb", i - 1), 32'(rgb1), 32'(vecs[i-1].e_rgb));
        chk($sformatf("vec%0d rgb_hit", i - 1), 32'(rgb_hit1), 32'(vecs[i-1].e_hit));
      end
    end

    // Background write coinciding with an output pixel
    drive(1'b1, 1'b0, 5'd0, 10'd0);
    tick();
    tick();
    chk("bg before write", 32'(rgb1), 32'h038);
    bg_wr   = 1'b1;
    bg_data = 9'h007;
    #1;
    chk("bg same-edge pixel", 32'(rgb1), 32'h038);
    tick();
    bg_wr = 1'b0;
    chk("bg next pixel", 32'(rgb1), 32'h007);
    chk("bg next hit", 32'(rgb_hit1), 32'd0);
    tick();
    chk("bg held", 32'(rgb1), 32'h007);

    // MEM_LATENCY=3 stream: alternating elements 0/5, no gaps
    for (int i = 0; i < 64; i++) begin
      exp3[i] = mem_fn(15'(((i % 2) != 0 ? 400 * 5 : 0) + 6 * i));
    end
    for (int j = 0; j < 67; j++) begin
      if (j < 64) drive(1'b1, 1'b1, (j % 2) != 0 ? 5'd5 : 5'd0, 10'(6 * j));
      else        drive(1'b0, 1'b0, 5'd0, 10'd0);
      tick();
      if (j >= 3) begin
        chk($sformatf("L3 stream %0d rgb", j - 3), 32'(rgb3), 32'(exp3[j-3]));
        chk($sformatf("L3 stream %0d hit", j - 3), 32'(rgb_hit3), 32'd1);
      end
    end

    // Reset in the middle of a hit burst
    drive(1'b1, 1'b1, 5'd5, 10'd17);
    repeat (3) tick();
    chk("burst rgb", 32'(rgb1), 32'h0A5);
    reset = 1'b0;
    tick();
    chk("midrst rgb", 32'(rgb1), 32'd0);
    chk("midrst hit", 32'(rgb_hit1), 32'd0);
    chk("midrst mem_rd", 32'(mem_rd1), 32'd0);
    chk("midrst mem_addr", 32'(mem_addr1), 32'd0);
    chk("midrst rgb L3", 32'(rgb3), 32'd0);
    reset = 1'b1;
    drive(1'b1, 1'b1, 5'd1, 10'd0);
    tick();
    chk("post1 rgb", 32'(rgb1), 32'd0);
    chk("post1 hit", 32'(rgb_hit1), 32'd0);
    chk("post1 mem_rd", 32'(mem_rd1), 32'd1);
    chk("post1 mem_addr", 32'(mem_addr1), 32'd400);
    chk("post1 hit L3", 32'(rgb_hit3), 32'd0);
    drive(1'b1, 1'b0, 5'd0, 10'd0);
    tick();
    chk("post2 rgb", 32'(rgb1), 32'h190);
    chk("post2 hit", 32'(rgb_hit1), 32'd1);
    chk("post2 hit L3", 32'(rgb_hit3), 32'd0);
    tick();
    chk("post3 bg cleared", 32'(rgb1), 32'd0);
    chk("post3 hit", 32'(rgb_hit1), 32'd0);
    chk("post3 hit L3", 32'(rgb_hit3), 32'd0);
    tick();
    chk("post4 rgb L3", 32'(rgb3), 32'h190);
    chk("post4 hit L3", 32'(rgb_hit3), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
